fifo_stream_reader: RTL and testbench
=====================================

Name: fifo_stream_reader

Overview:
- Read-side consumer for the team's FIFOs. Runs in the FIFO read-clock domain and drives the FIFO read port (rd_en/rd_data/empty).
- Converts the FIFO's registered one-cycle-latency read into a valid/ready output stream, using a 2-entry output buffer so data is never lost under backpressure.
- Frames the stream into fixed-length bursts (m_last) and can start or stop draining on burst boundaries under control of an enable input.

Parameters:
- WIDTH, 8, data width; matches the FIFO data width.
- BURST, 4, beats per burst; must be >= 2. m_last is asserted on the final beat of each burst.
- CNT_W, 16, width of the beats_sent counter.

Ports:
- rd_clk  input  1  block clock, the FIFO read clock
- rstn  input  1  asynchronous active-low reset
- en  input  1  drain enable
- fifo_empty  input  1  FIFO empty flag
- fifo_rd_data  input  WIDTH  FIFO read data; valid the cycle after an accepted read
- fifo_rd_en  output  1  FIFO read request
- m_valid  output  1  output beat valid
- m_data  output  WIDTH  output beat data
- m_last  output  1  final beat of a burst; qualified by m_valid
- m_ready  input  1  downstream accept
- busy  output  1  high when state is not IDLE
- beats_sent  output  CNT_W  count of completed output transfers; wraps modulo 2^CNT_W

Behaviour:
- Reset (asynchronous, rstn=0):
  - state=IDLE, buffer count=0, inflight=0, issue_cnt=0, out_cnt=0.
  - m_valid=0, m_data=0, m_last=0, busy=0, beats_sent=0, fifo_rd_en=0.
  - Reset mid-operation discards buffered and in-flight data.
- Definitions:
  - pop = m_valid && m_ready.
  - issue = fifo_rd_en && !fifo_empty.
  - inflight: 1-bit register, set to issue each cycle.
  - buf_cnt: 0..2.
- Read issue: fifo_rd_en is combinational and is high only when all of the following hold:
  - state is RUN, or state is DRAIN with issue_cnt != 0;
  - !fifo_empty;
  - buf_cnt + inflight - pop < 2.
  - The combinational path m_ready -> fifo_rd_en is allowed. It gives 1 beat/cycle sustained throughput.
- Capture: when inflight=1, fifo_rd_data is written into the buffer tail that cycle. A capture and a pop in the same cycle leave buf_cnt unchanged. Strict FIFO ordering is preserved.
- Output:
  - m_valid = (buf_cnt != 0).
  - m_data = buffer head.
  - m_last = m_valid && (out_cnt == BURST-1).
  - m_data and m_last must stay stable while m_valid && !m_ready.
- Counters:
  - issue_cnt increments on each issue, modulo BURST.
  - out_cnt increments on each pop, modulo BURST.
  - beats_sent increments on each pop.
- State machine (IDLE, RUN, DRAIN):
  - IDLE -> RUN when en=1.
  - RUN -> DRAIN when en=0.
  - DRAIN -> RUN when en=1.
  - DRAIN -> IDLE when issue_cnt==0, inflight==0 and buf_cnt==0. A stopped drain therefore always ends on a completed burst.
  - No reads are issued in IDLE.
- Boundary conditions:
  - fifo_empty mid-burst: issuing stalls and m_valid drops once the buffer empties. Burst framing continues from the same out_cnt when data resumes.
  - Buffer full (buf_cnt=2, no pop): fifo_rd_en=0. Overflow of the buffer is impossible by construction.
  - en toggling within DRAIN: returns to RUN with counters intact.
  - fifo_rd_en is never asserted while fifo_empty=1, so this block never causes an underflow.
- Latency: first m_valid appears 2 cycles after the first issue (issue edge -> FIFO rd_data edge -> buffer write edge).

Test Plan:
- Reset: hold rstn=0 with en=1 and FIFO non-empty -> all outputs 0 and fifo_rd_en=0. After release, the first fifo_rd_en occurs on the first edge with en=1.
- Streaming, BURST=4: FIFO preloaded with 0x11,0x22,…,0x88, m_ready=1 -> m_data 0x11..0x88 on consecutive cycles after 2-cycle latency; m_last on 0x44 and 0x88; beats_sent=8.
- Backpressure: 8 entries, m_ready=0 for 6 cycles -> exactly 2 reads issued, m_data holds 0x11. On m_ready=1, all 8 beats are delivered in order with no loss or duplicates.
- Stop mid-burst: en dropped after the 2nd beat of a burst -> exactly 2 more beats are read and sent, the last with m_last=1. Then IDLE, busy=0, fifo_rd_en=0, and 4 entries remain in the FIFO.
- Empty gap: 3 entries, then 5 more written 10 cycles later -> m_valid low during the gap. m_last on overall beats 4 and 8; fifo_rd_en never high while fifo_empty=1.
- Reset mid-burst: rstn pulsed low with buf_cnt=2 -> m_valid=0 immediately, beats_sent=0, and the next burst starts with out_cnt=0.

Source files
------------

// File: rtl/fifo_stream_reader.sv
// Read-side FIFO consumer: turns the one-cycle-latency FIFO read into a valid/ready
// stream through a 2-entry skid buffer, framed into fixed-length bursts by m_last.
module fifo_stream_reader #(
  parameter int WIDTH = 8,
  parameter int BURST = 4,  // beats per burst, must be >= 2
  parameter int CNT_W = 16
) (
  input  logic             rd_clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rd_data,
  output logic             fifo_rd_en,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  input  logic             m_ready,
  output logic             busy,
  output logic [CNT_W-1:0] beats_sent
);

  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] buf_mem [2];
  logic             head;
  logic [1:0]       buf_cnt;
  logic             inflight;
  logic [BW-1:0]    issue_cnt;
  logic [BW-1:0]    out_cnt;

  logic             pop;
  logic             issue;
  logic             read_window;
  logic             room;
  logic             drained;
  logic             tail;
  logic [2:0]       occupancy;

  // Stream handshake: a beat transfers on a cycle where m_valid && m_ready at the
  // rising edge; while m_valid is high and m_ready low, m_data/m_last hold.
  assign pop = m_valid && m_ready;

  // Entries held plus the one arriving next cycle, minus the one leaving now.
  // pop implies buf_cnt >= 1, so this never wraps below zero.
  assign occupancy = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign room      = (occupancy < 3'd2);

  // In DRAIN, reads continue only until the current burst has been fully issued.
  assign read_window = (state == RUN) || ((state == DRAIN) && (issue_cnt != '0));
  assign fifo_rd_en  = read_window && !fifo_empty && room;
  assign issue       = fifo_rd_en && !fifo_empty;

  assign drained = (issue_cnt == '0) && !inflight && (buf_cnt == 2'd0);

  // Next free slot; when one entry is held the tail is the other slot.
  assign tail = head ^ buf_cnt[0];

  assign m_valid = (buf_cnt != 2'd0);
  assign m_data  = buf_mem[head];
  assign m_last  = m_valid && (out_cnt == LAST_BEAT);
  assign busy    = (state != IDLE);

  always_ff @(posedge rd_clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (en) state <= RUN;
        end
        RUN: begin
          if (!en) state <= DRAIN;
        end
        DRAIN: begin
          if (en)           state <= RUN;
          else if (drained) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge rd_clk or negedge rstn) begin
    if (!rstn) begin
      buf_mem[0] <= '0;
      buf_mem[1] <= '0;
      head       <= 1'b0;
      buf_cnt    <= 2'd0;
      inflight   <= 1'b0;
    end else begin
      inflight <= issue;
      if (inflight) buf_mem[tail] <= fifo_rd_data;
      if (pop)      head <= ~head;
      case ({inflight, pop})
        2'b10:   buf_cnt <= buf_cnt + 2'd1;
        2'b01:   buf_cnt <= buf_cnt - 2'd1;
        default: buf_cnt <= buf_cnt;
      endcase
    end
  end

  always_ff @(posedge rd_clk or negedge rstn) begin
    if (!rstn) begin
      issue_cnt  <= '0;
      out_cnt    <= '0;
      beats_sent <= '0;
    end else begin
      if (issue) begin
        issue_cnt <= (issue_cnt == LAST_BEAT) ? '0 : issue_cnt + 1'b1;
      end
      if (pop) begin
        out_cnt    <= (out_cnt == LAST_BEAT) ? '0 : out_cnt + 1'b1;
        beats_sent <= beats_sent + 1'b1;
      end
    end
  end

`ifndef SYNTHESIS
  a_no_underflow: assert property (@(posedge rd_clk) disable iff (!rstn)
    fifo_rd_en |-> !fifo_empty);

  a_no_overflow: assert property (@(posedge rd_clk) disable iff (!rstn)
    !((buf_cnt == 2'd2) && inflight && !pop));

  a_buf_range: assert property (@(posedge rd_clk) disable iff (!rstn)
    buf_cnt != 2'd3);

  a_hold: assert property (@(posedge rd_clk) disable iff (!rstn)
    (m_valid && !m_ready) |=> (m_valid && $stable(m_data) && $stable(m_last)));
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: queue-based FIFO model, scoreboard on every beat,
// hand-written corner sequences and a table of randomized streaming runs.
module tb_fifo_stream_reader;
  localparam int WIDTH = 8;
  localparam int BURST = 4;
  localparam int CNT_W = 16;

  logic             rd_clk = 1'b0;
  logic             rstn = 1'b0;
  logic             en = 1'b0;
  logic             fifo_empty = 1'b1;
  logic [WIDTH-1:0] fifo_rd_data = '0;
  logic             fifo_rd_en;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_last;
  logic             m_ready = 1'b0;
  logic             busy;
  logic [CNT_W-1:0] beats_sent;

  fifo_stream_reader #(.WIDTH(WIDTH), .BURST(BURST), .CNT_W(CNT_W)) dut (
    .rd_clk      (rd_clk),
    .rstn        (rstn),
    .en          (en),
    .fifo_empty  (fifo_empty),
    .fifo_rd_data(fifo_rd_data),
    .fifo_rd_en  (fifo_rd_en),
    .m_valid     (m_valid),
    .m_data      (m_data),
    .m_last      (m_last),
    .m_ready     (m_ready),
    .busy        (busy),
    .beats_sent  (beats_sent)
  );

  // ---------------- clock / reset ----------------
  always #5 rd_clk = ~rd_clk;

  // ---------------- scoreboard state ----------------
  int               n_checks = 0;
  int               n_errors = 0;
  logic [WIDTH-1:0] fifo_q [$];
  logic [WIDTH-1:0] exp_q [$];
  int               model_sent = 0;
  int               model_out = 0;
  int               n_reads = 0;
  int               ready_pct = 100;
  logic             prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_data = '0;
  logic             prev_last = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // FIFO model: registered read, data appears the cycle after an accepted read.
  always @(posedge rd_clk) begin
    logic [WIDTH-1:0] rd_tmp;
    if (fifo_rd_en && fifo_q.size() != 0) begin
      rd_tmp = fifo_q.pop_front();
      fifo_rd_data <= rd_tmp;
      n_reads++;
    end
    fifo_empty <= (fifo_q.size() == 0);
  end

  // Downstream ready: percentage chance per cycle (0 = stall, 100 = always).
  always @(posedge rd_clk) begin
    #2;
    m_ready = ($urandom_range(0, 99) < ready_pct);
  end

  // Reference model: every beat must be the oldest undelivered FIFO word, every
  // BURST-th beat carries m_last, and a reset loses whatever left the FIFO.
  always @(negedge rd_clk) begin
    if (!rstn) begin
      exp_q      = fifo_q;
      model_sent = 0;
      model_out  = 0;
      prev_stall = 1'b0;
    end else begin
      if (fifo_empty) check("no_read_when_empty", 32'(fifo_rd_en), 32'd0);
      check("beats_sent", 32'(beats_sent), 32'(model_sent[CNT_W-1:0]));
      if (prev_stall) begin
        check("hold_valid", 32'(m_valid), 32'd1);
        check("hold_data", 32'(m_data), 32'(prev_data));
        check("hold_last", 32'(m_last), 32'(prev_last));
      end
      if (!m_valid) check("last_needs_valid", 32'(m_last), 32'd0);
      if (m_valid && m_ready) begin
        check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("beat_data", 32'(m_data), 32'(exp_q.pop_front()));
        check("beat_last", 32'(m_last), 32'(model_out == BURST - 1));
        model_out = (model_out + 1) % BURST;
        model_sent++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge rd_clk);
      #1;
    end
  endtask

  task automatic push(input logic [WIDTH-1:0] d);
    fifo_q.push_back(d);
    if (rstn) exp_q.push_back(d);
    fifo_empty = 1'b0;
  endtask

  task automatic wait_sent(input int target, input int budget);
    int n = 0;
    while (model_sent < target && n < budget) begin
      cyc(1);
      n++;
    end
    check("wait_sent_in_budget", 32'(model_sent >= target), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      cyc(1);
      n++;
    end
    check("wait_idle_in_budget", 32'(busy), 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int n_pre;
    int gap;
    int n_late;
    int rdy;
    bit toggle;
    int exp_delta;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    vecs[0] = '{n_pre: 4, gap: 0,  n_late: 0,  rdy: 100, toggle: 1'b0, exp_delta: 4};
    vecs[1] = '{n_pre: 5, gap: 7,  n_late: 3,  rdy: 50,  toggle: 1'b0, exp_delta: 8};
    vecs[2] = '{n_pre: 2, gap: 15, n_late: 10, rdy: 30,  toggle: 1'b1, exp_delta: 12};
    vecs[3] = '{n_pre: 8, gap: 3,  n_late: 4,  rdy: 75,  toggle: 1'b1, exp_delta: 12};
    vecs[4] = '{n_pre: 1, gap: 20, n_late: 7,  rdy: 90,  toggle: 1'b0, exp_delta: 8};
    vecs[5] = '{n_pre: 6, gap: 0,  n_late: 2,  rdy: 10,  toggle: 1'b1, exp_delta: 8};

    // Reset with en=1 and a non-empty FIFO, then streaming 0x11..0x88.
    ready_pct = 100;
    en = 1'b1;
    cyc(2);
    for (int i = 0; i < 8; i++) push(8'((i + 1) * 17));
    cyc(2);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_beats_sent", 32'(beats_sent), 32'd0);
    check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    rstn = 1'b1;
    check("idle_rd_en", 32'(fifo_rd_en), 32'd0);
    cyc(1);
    check("first_rd_en", 32'(fifo_rd_en), 32'd1);
    check("first_busy", 32'(busy), 32'd1);
    cyc(1);
    check("latency_no_valid", 32'(m_valid), 32'd0);
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      check("stream_valid", 32'(m_valid), 32'd1);
      check("stream_data", 32'(m_data), 32'((i + 1) * 17));
    end
    wait_sent(8, 50);
    check("stream_beats", 32'(beats_sent), 32'd8);
    en = 1'b0;
    wait_idle(50);
    check("stream_idle_rd_en", 32'(fifo_rd_en), 32'd0);

    // Backpressure: only two reads fit while the consumer stalls.
    ready_pct = 0;
    for (int i = 0; i < 8; i++) push(8'((i + 1) * 17));
    cyc(1);
    en = 1'b1;
    base = n_reads;
    cyc(6);
    check("bp_reads", 32'(n_reads - base), 32'd2);
    check("bp_valid", 32'(m_valid), 32'd1);
    check("bp_data", 32'(m_data), 32'h11);
    ready_pct = 100;
    wait_sent(16, 100);
    check("bp_beats", 32'(beats_sent), 32'd16);
    en = 1'b0;
    wait_idle(50);

    // Stop after the 2nd beat of a burst: the burst completes, then IDLE.
    for (int i = 0; i < 8; i++) push(8'(8'hA0 + i));
    en = 1'b1;
    wait_sent(18, 50);
    en = 1'b0;
    ready_pct = 0;
    cyc(3);
    check("stop_still_busy", 32'(busy), 32'd1);
    ready_pct = 100;
    wait_sent(20, 50);
    wait_idle(50);
    cyc(2);
    check("stop_beats", 32'(beats_sent), 32'd20);
    check("stop_rd_en", 32'(fifo_rd_en), 32'd0);
    check("stop_left_in_fifo", 32'(fifo_q.size()), 32'd4);

    // Empty gap: drain leftovers, then 3 entries, a gap, then 5 more.
    en = 1'b1;
    wait_sent(24, 60);
    for (int i = 0; i < 3; i++) push(8'(8'hC0 + i));
    wait_sent(27, 40);
    cyc(4);
    check("gap_valid_low", 32'(m_valid), 32'd0);
    check("gap_rd_en_low", 32'(fifo_rd_en), 32'd0);
    check("gap_still_busy", 32'(busy), 32'd1);
    cyc(6);
    for (int i = 3; i < 8; i++) push(8'(8'hC0 + i));
    wait_sent(32, 60);
    en = 1'b0;
    wait_idle(50);
    check("gap_beats", 32'(beats_sent), 32'd32);

    // Randomized table runs.
    for (int v = 0; v < 6; v++) begin
      base = model_sent;
      ready_pct = vecs[v].rdy;
      for (int i = 0; i < vecs[v].n_pre; i++) push(8'($urandom));
      en = 1'b1;
      if (vecs[v].toggle) begin
        cyc(3);
        en = 1'b0;
        cyc(2);
        en = 1'b1;
      end
      cyc(vecs[v].gap);
      for (int i = 0; i < vecs[v].n_late; i++) push(8'($urandom));
      wait_sent(base + vecs[v].exp_delta, 2000);
      en = 1'b0;
      wait_idle(200);
      cyc(1);
      check("tbl_beats", 32'(beats_sent), 32'(base + vecs[v].exp_delta));
      check("tbl_rd_en", 32'(fifo_rd_en), 32'd0);
      check("tbl_valid", 32'(m_valid), 32'd0);
      check("tbl_fifo_drained", 32'(fifo_q.size()), 32'd0);
    end

    // Reset mid-burst with the output buffer full.
    ready_pct = 0;
    for (int i = 0; i < 8; i++) push(8'(8'hE0 + i));
    en = 1'b1;
    cyc(6);
    check("mid_pre_valid", 32'(m_valid), 32'd1);
    #3;
    rstn = 1'b0;
    #1;
    check("mid_rst_valid", 32'(m_valid), 32'd0);
    check("mid_rst_beats", 32'(beats_sent), 32'd0);
    check("mid_rst_last", 32'(m_last), 32'd0);
    check("mid_rst_rd_en", 32'(fifo_rd_en), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    cyc(2);
    rstn = 1'b1;
    ready_pct = 100;
    push(8'hF0);
    push(8'hF1);
    wait_sent(8, 100);
    check("mid_after_beats", 32'(beats_sent), 32'd8);
    en = 1'b0;
    wait_idle(50);
    check("mid_fifo_drained", 32'(fifo_q.size()), 32'd0);

    cyc(2);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
